// File: rtl/ppd_ctrl_if.sv
// ppd_ctrl_if: host configuration, detector strobes and detector configuration
// bundle for the packet-presence-detection sequencer.
//   host_cfg_*       host shadow-register write (strobe + enable/threshold/len)
//   host_clear       request to clear the detector running sums
//   host_cnt_clr     request to zero the packet counter
//   in_valid         detector input sample strobe
//   det_valid        detector output sample strobe
//   ppd_cfg_*        configuration driven into the detector
//   pkt_count        packets detected (wraps)
//   state            sequencer state for host readback
interface ppd_ctrl_if;
    localparam int unsigned THR_W = 8;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned PKT_W = 32;
    localparam int unsigned ST_W  = 3;

    logic               host_cfg_wr;
    logic               host_cfg_enable;
    logic [THR_W-1:0]   host_cfg_threshold;
    logic [LEN_W-1:0]   host_cfg_passthrough_len;
    logic               host_clear;
    logic               host_cnt_clr;
    logic               in_valid;
    logic               det_valid;

    logic               ppd_cfg_enable;
    logic               ppd_cfg_clear_rs;
    logic [THR_W-1:0]   ppd_cfg_threshold;
    logic [LEN_W-1:0]   ppd_cfg_passthrough_len;
    logic [PKT_W-1:0]   pkt_count;
    logic [ST_W-1:0]    state;

    // Host / stimulus side
    modport master (
        output host_cfg_wr, host_cfg_enable, host_cfg_threshold, host_cfg_passthrough_len,
               host_clear, host_cnt_clr, in_valid, det_valid,
        input  ppd_cfg_enable, ppd_cfg_clear_rs, ppd_cfg_threshold, ppd_cfg_passthrough_len,
               pkt_count, state
    );

    // Sequencer side
    modport slave (
        input  host_cfg_wr, host_cfg_enable, host_cfg_threshold, host_cfg_passthrough_len,
               host_clear, host_cnt_clr, in_valid, det_valid,
        output ppd_cfg_enable, ppd_cfg_clear_rs, ppd_cfg_threshold, ppd_cfg_passthrough_len,
               pkt_count, state
    );
endinterface

// File: rtl/ppd_ctrl.sv
// ppd_ctrl: sequencer for the packet-presence-detection stage.
// Clears the detector running sums on enable, suppresses detection through a
// warm-up, arms the detector, tracks each passthrough burst to its programmed
// length and applies a hold-off before re-arming. Counts detected packets.
//   clk_clk        clock
//   reset_reset_n  asynchronous active-low reset
//   bus            ppd_ctrl_if.slave (host config in, detector config out)
module ppd_ctrl #(
    parameter int unsigned CLEAR_CYCLES    = 2,
    parameter int unsigned WARMUP_SAMPLES  = 256,
    parameter int unsigned HOLDOFF_SAMPLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    ppd_ctrl_if.slave   bus
);
    localparam int unsigned THR_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PKT_W = 32;

    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARMUP_LAST  = CNT_W'(WARMUP_SAMPLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_SAMPLES - 1);
    localparam logic [THR_W-1:0] THR_BLOCK    = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        WARMUP  = 3'd2,
        ARMED   = 3'd3,
        PASS    = 3'd4,
        HOLDOFF = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [THR_W-1:0]   thr_q, thr_sh_d;
    logic [CNT_W-1:0]   len_q, len_sh_d;
    logic               en_q, en_sh_d;
    logic               pend_q, pend_d;
    logic               pend_next;
    logic               burst_done;
    logic               pkt_inc;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic               cfg_en_q, cfg_en_d;
    logic               clear_rs_q, clear_rs_d;
    logic [THR_W-1:0]   thr_out_q, thr_out_d;

    // State register, shadow registers, counters and registered outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            thr_q      <= '0;
            len_q      <= '0;
            en_q       <= 1'b0;
            pend_q     <= 1'b0;
            pkt_q      <= '0;
            cfg_en_q   <= 1'b0;
            clear_rs_q <= 1'b0;
            thr_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            thr_q      <= thr_sh_d;
            len_q      <= len_sh_d;
            en_q       <= en_sh_d;
            pend_q     <= pend_d;
            pkt_q      <= pkt_d;
            cfg_en_q   <= cfg_en_d;
            clear_rs_q <= clear_rs_d;
            thr_out_q  <= thr_out_d;
        end
    end

    // Next-state, counter and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_next  = pend_q | bus.host_clear;
        burst_done = 1'b0;
        pkt_inc    = 1'b0;
        thr_sh_d   = thr_q;
        len_sh_d   = len_q;
        en_sh_d    = en_q;

        if (bus.host_cfg_wr) begin
            thr_sh_d = bus.host_cfg_threshold;
            len_sh_d = bus.host_cfg_passthrough_len;
            en_sh_d  = bus.host_cfg_enable;
        end

        if (bus.host_cfg_wr) begin
            // Any config write restarts the sequence from scratch
            state_d = bus.host_cfg_enable ? CLEAR : IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                CLEAR: begin
                    if (bus.host_clear) begin
                        cnt_d = '0;
                    end else if (cnt_q == CLEAR_LAST) begin
                        state_d = WARMUP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WARMUP: begin
                    if (bus.host_clear) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else if (bus.in_valid) begin
                        if (cnt_q == WARMUP_LAST) begin
                            state_d = ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (bus.host_clear) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else if (bus.det_valid) begin
                        // The detecting beat is burst sample 1
                        state_d = PASS;
                        cnt_d   = CNT_W'(1);
                        pkt_inc = 1'b1;
                    end
                end
                PASS: begin
                    // cnt_q >= len_q covers len 0/1: the arming beat already ended it
                    burst_done = (cnt_q >= len_q) ||
                                 (bus.det_valid && ((cnt_q + CNT_W'(1)) == len_q));
                    if (burst_done) begin
                        state_d = pend_next ? CLEAR : HOLDOFF;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end else begin
                        pend_d = pend_next;
                        if (bus.det_valid) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLDOFF: begin
                    if (bus.host_clear) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else if (bus.in_valid) begin
                        if (cnt_q == HOLDOFF_LAST) begin
                            state_d = ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end

        // Counter clear wins over the old value but not over a same-cycle packet
        if (bus.host_cnt_clr) begin
            pkt_d = PKT_W'(pkt_inc);
        end else begin
            pkt_d = pkt_q + PKT_W'(pkt_inc);
        end

        // Outputs computed from the next state so they line up with state_q
        cfg_en_d   = en_sh_d && (state_d != IDLE);
        clear_rs_d = (state_d == CLEAR);
        unique case (state_d)
            IDLE, ARMED, PASS: thr_out_d = thr_sh_d;
            default:           thr_out_d = THR_BLOCK;
        endcase
    end

    assign bus.ppd_cfg_enable          = cfg_en_q;
    assign bus.ppd_cfg_clear_rs        = clear_rs_q;
    assign bus.ppd_cfg_threshold       = thr_out_q;
    assign bus.ppd_cfg_passthrough_len = len_q;
    assign bus.pkt_count               = pkt_q;
    assign bus.state                   = state_q;
endmodule

// File: doc/ppd_ctrl.md
# ppd_ctrl

Sequencer for the packet-presence-detection stage of the lms_dsp datapath. It takes host configuration writes and drives the detector's `ppd_cfg_*` inputs. On each enable it clears the running sums, then suppresses detection through a warm-up period. It arms the detector, tracks each passthrough burst to its programmed length, and applies a hold-off before re-arming. It also counts detected packets for host readback.

## Interface
- `CLEAR_CYCLES`, default 2: cycles `ppd_cfg_clear_rs` is held high per clear.
- `WARMUP_SAMPLES`, default 256: input samples to skip after a clear before arming (≥1).
- `HOLDOFF_SAMPLES`, default 1024: input samples to skip after each packet before re-arming (≥1).

Ports:
- `clk_clk`  in  1  single clock domain.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `host_cfg_wr`  in  1  one-cycle strobe; samples the three `host_cfg_*` fields below.
- `host_cfg_enable`  in  1  requested run state.
- `host_cfg_threshold`  in  8  programmed detection threshold.
- `host_cfg_passthrough_len`  in  16  samples per packet burst.
- `host_clear`  in  1  one-cycle request to clear the running sums.
- `host_cnt_clr`  in  1  one-cycle request to zero `pkt_count`.
- `in_valid`  in  1  detector input sample strobe (`fifo_in_wrreq`).
- `det_valid`  in  1  detector output sample strobe (PPD source valid).
- `ppd_cfg_enable`  out  1  drives the detector enable.
- `ppd_cfg_clear_rs`  out  1  drives the running-sum clear.
- `ppd_cfg_threshold`  out  8  threshold presented to the detector.
- `ppd_cfg_passthrough_len`  out  16  programmed burst length.
- `pkt_count`  out  32  packets detected; wraps modulo 2^32.
- `state`  out  3  encoding: IDLE=0, CLEAR=1, WARMUP=2, ARMED=3, PASS=4, HOLDOFF=5.

## Operation
- Shadow registers `thr_q`, `len_q` and `en_q` load on `host_cfg_wr`. `ppd_cfg_passthrough_len` = `len_q` at all times.
- **IDLE:** `ppd_cfg_enable`=0, `ppd_cfg_clear_rs`=0, threshold output = `thr_q`.
  - `host_cfg_wr` with enable=1 → CLEAR.
- **CLEAR:** `ppd_cfg_enable`=1, `ppd_cfg_clear_rs`=1, threshold = 8'hFF.
  - Stays exactly `CLEAR_CYCLES` cycles, then → WARMUP.
- **WARMUP:** `ppd_cfg_enable`=1, threshold forced to 8'hFF.
  - Counts `in_valid` beats; at the `WARMUP_SAMPLES`-th beat → ARMED.
- **ARMED:** threshold = `thr_q`.
  - First `det_valid` → PASS; `pkt_count` increments in the same cycle.
  - That beat counts as burst sample 1.
- **PASS:** counts `det_valid` beats.
  - At the beat where the count reaches `len_q` → HOLDOFF.
  - If `len_q`=0 or 1, the first beat alone ends the burst (ARMED → PASS → HOLDOFF on consecutive cycles).
- **HOLDOFF:** threshold forced to 8'hFF.
  - Counts `in_valid` beats; at the `HOLDOFF_SAMPLES`-th beat → ARMED.
  - `det_valid` during HOLDOFF is ignored and not counted.
- **Priority, highest first** (any state):
  1. `host_cfg_wr` with enable=0 → IDLE.
  2. `host_cfg_wr` with enable=1 → CLEAR (restart with the new shadow values).
  3. `host_clear`.
- **`host_clear` handling:**
  - In WARMUP, ARMED or HOLDOFF → CLEAR.
  - In CLEAR → the CLEAR cycle count restarts.
  - In PASS → latched as pending; on PASS exit the FSM goes to CLEAR instead of HOLDOFF.
  - In IDLE → ignored.
- **`pkt_count`:**
  - `host_cnt_clr` zeroes it.
  - If `host_cnt_clr` coincides with an increment, the result is 1.
  - It is not affected by enable or clear.

## Timing
- All outputs are registered and change on the clock edge after the triggering input. State-derived outputs follow the registered state with no combinational input-to-output path.
- `host_cfg_wr` with enable=1 at edge N:
  - `state`=CLEAR and `ppd_cfg_clear_rs`=1 on cycles N+1 .. N+`CLEAR_CYCLES`.
  - WARMUP on N+`CLEAR_CYCLES`+1.
- ARMED → PASS on the edge after the first `det_valid`. `pkt_count` updates on that same edge.
- `in_valid` and `det_valid` may be high every cycle; no back-pressure is applied.
- Counters are 16 bit for sample counts and 32 bit for `pkt_count`.
- Reset (asynchronous, any time including mid-PASS):
  - state=IDLE, `ppd_cfg_enable`=0, `ppd_cfg_clear_rs`=0.
  - threshold output=0, `thr_q`=0, `len_q`=0, `en_q`=0.
  - `pkt_count`=0, pending clear=0, all counters=0.

## Test plan
- **Enable sequence.**
  - Stimulus: reset, write enable=1, threshold=40, len=100; `in_valid` every cycle.
  - Required: `clear_rs` high exactly 2 cycles; threshold=FF for 256 samples; ARMED with threshold=40 on the cycle after sample 256.
- **Packet burst.**
  - Stimulus: in ARMED, 100 consecutive `det_valid`.
  - Required: `pkt_count` 0→1 one edge after the first beat; HOLDOFF after beat 100; 1024 `in_valid` later, ARMED again.
- **Hold-off suppression.**
  - Stimulus: `det_valid` pulses during HOLDOFF.
  - Required: `pkt_count` unchanged; state stays HOLDOFF until 1024 `in_valid` beats.
- **Clear during PASS.**
  - Stimulus: `host_clear` at burst beat 50 of 100.
  - Required: PASS continues to beat 100, then CLEAR (not HOLDOFF), then WARMUP.
- **Disable mid-WARMUP and same-cycle `cnt_clr`.**
  - Stimulus: write enable=0 during WARMUP.
  - Required: IDLE next cycle, `ppd_cfg_enable`=0.
  - Stimulus: `host_cnt_clr` on the same edge as a packet increment.
  - Required: `pkt_count`=1.
- **Async reset mid-PASS.**
  - Stimulus: assert `reset_reset_n` low with no clock edge.
  - Required: outputs reach reset values immediately; after release, state stays IDLE until a new `host_cfg_wr`.
